// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read-master bus between the sample reader and the flash controller.
interface flash_sample_reader_if #(
    parameter int unsigned FLASH_ADDR_W = 23
);
    logic                    flash_mem_read;
    logic [FLASH_ADDR_W-1:0] flash_mem_address;
    logic [3:0]              flash_mem_byteenable;
    logic                    flash_mem_waitrequest;
    logic [31:0]             flash_mem_readdata;
    logic                    flash_mem_readdatavalid;

    modport master (
        output flash_mem_read,
        output flash_mem_address,
        output flash_mem_byteenable,
        input  flash_mem_waitrequest,
        input  flash_mem_readdata,
        input  flash_mem_readdatavalid
    );

    modport slave (
        input  flash_mem_read,
        input  flash_mem_address,
        input  flash_mem_byteenable,
        output flash_mem_waitrequest,
        output flash_mem_readdata,
        output flash_mem_readdatavalid
    );
endinterface

// File: rtl/flash_sample_reader.sv
// Fetches 32-bit words from flash at the address counter's position, advances
// the counter after each fetch, and plays each word out as two 16-bit samples.
module flash_sample_reader #(
    parameter int unsigned FLASH_ADDR_W = 23,
    parameter int unsigned ADV_TIMEOUT  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dir,
    input  logic                  enable,
    input  logic                  sample_tick,
    input  logic [31:0]           current_address,
    input  logic                  addr_retrieved_flag,
    output logic                  read_addr_flag,
    flash_sample_reader_if.master flash,
    output logic [15:0]           sample_out,
    output logic                  sample_valid,
    output logic                  busy,
    output logic [7:0]            underrun_count,
    output logic                  adv_error
);

    localparam int unsigned TMR_W = (ADV_TIMEOUT > 1) ? $clog2(ADV_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        ADVANCE,
        ADV_WAIT,
        READY
    } state_t;

    state_t                  state_q, state_d;
    logic                    flag_q, flag_d;
    logic                    read_q, read_d;
    logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]             word_q, word_d;
    logic                    word_dir_q, word_dir_d;
    logic                    half_q, half_d;
    logic [15:0]             sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic [7:0]              under_q, under_d;
    logic                    err_q, err_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;

    // Upper counter address bits lie outside the flash word space.
    logic unused_addr_hi;
    assign unused_addr_hi = ^current_address[31:FLASH_ADDR_W];

    // State and output registers; reset aborts any fetch in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            flag_q     <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= '0;
            word_q     <= '0;
            word_dir_q <= 1'b0;
            half_q     <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            under_q    <= '0;
            err_q      <= 1'b0;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            flag_q     <= flag_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            word_dir_q <= word_dir_d;
            half_q     <= half_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            under_q    <= under_d;
            err_q      <= err_d;
            tmr_q      <= tmr_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d    = state_q;
        flag_d     = 1'b0;
        read_d     = read_q;
        addr_d     = addr_q;
        word_d     = word_q;
        word_dir_d = word_dir_q;
        half_d     = half_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        under_d    = under_q;
        err_d      = err_q;
        tmr_d      = tmr_q;

        // A tick that arrives while no word is ready is a lost sample.
        if (sample_tick && enable && (state_q != READY) && (under_q != 8'hFF)) begin
            under_d = under_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                state_d = FETCH_REQ;
                read_d  = 1'b1;
                addr_d  = current_address[FLASH_ADDR_W-1:0];
            end
            FETCH_REQ: begin
                if (!flash.flash_mem_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (flash.flash_mem_readdatavalid) begin
                    word_d     = flash.flash_mem_readdata;
                    word_dir_d = dir;
                    flag_d     = 1'b1;
                    state_d    = ADVANCE;
                end
            end
            ADVANCE: begin
                tmr_d   = '0;
                state_d = ADV_WAIT;
            end
            ADV_WAIT: begin
                if (addr_retrieved_flag) begin
                    half_d  = 1'b0;
                    state_d = READY;
                end else if (tmr_q == TMR_W'(ADV_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    half_d  = 1'b0;
                    state_d = READY;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            READY: begin
                if (sample_tick && enable) begin
                    valid_d = 1'b1;
                    if (!half_q) begin
                        sample_d = word_dir_q ? word_q[15:0] : word_q[31:16];
                        half_d   = 1'b1;
                    end else begin
                        sample_d = word_dir_q ? word_q[31:16] : word_q[15:0];
                        half_d   = 1'b0;
                        read_d   = 1'b1;
                        addr_d   = current_address[FLASH_ADDR_W-1:0];
                        state_d  = FETCH_REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output drive.
    assign read_addr_flag             = flag_q;
    assign flash.flash_mem_read       = read_q;
    assign flash.flash_mem_address    = addr_q;
    assign flash.flash_mem_byteenable = 4'hF;
    assign sample_out                 = sample_q;
    assign sample_valid               = valid_q;
    assign underrun_count             = under_q;
    assign adv_error                  = err_q;
    assign busy                       = (state_q != READY);

endmodule
